// File: rtl/interrupt_sequencer_if.sv
// Handshake between the control unit and the interrupt sequencer: request inputs,
// bus-ready, status image, and the push/vector-fetch strobes the sequencer drives.
interface interrupt_sequencer_if;
  logic        instr_bound;
  logic        brk_req;
  logic        irq_n;
  logic        nmi_n;
  logic        bus_ready;
  logic [7:0]  psr_in;
  logic        seq_active;
  logic        push_pch;
  logic        push_pcl;
  logic        push_psr;
  logic [7:0]  psr_push;
  logic        set_i;
  logic [15:0] vec_addr;
  logic        load_vec_lo;
  logic        load_vec_hi;
  logic        seq_done;

  modport master (
    input  instr_bound, brk_req, irq_n, nmi_n, bus_ready, psr_in,
    output seq_active, push_pch, push_pcl, push_psr, psr_push, set_i,
           vec_addr, load_vec_lo, load_vec_hi, seq_done
  );

  modport slave (
    output instr_bound, brk_req, irq_n, nmi_n, bus_ready, psr_in,
    input  seq_active, push_pch, push_pcl, push_psr, psr_push, set_i,
           vec_addr, load_vec_lo, load_vec_hi, seq_done
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// BRK/IRQ/NMI entry sequencer: arbitrates at instruction boundaries, then pushes
// PCH, PCL, P and fetches the vector, with NMI hijack of in-flight BRK/IRQ entries.
//
// state    | meaning
// IDLE     | waiting for an instruction boundary with a pending source
// PUSH_PCH | writing PC[15:8] to the stack
// PUSH_PCL | writing PC[7:0] to the stack
// PUSH_P   | writing the status image (B resolved) to the stack
// VEC_LO   | loading PCL from the vector, setting I
// VEC_HI   | loading PCH from the vector
module interrupt_sequencer #(
  parameter logic [15:0] NMI_VEC = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
  input logic clk,
  input logic nrst,
  interrupt_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_BRK, SRC_NMI, SRC_IRQ} src_t;

  state_t      state, state_nxt;
  src_t        src, start_src;
  logic        nmi_q, nmi_pend, nmi_edge, nmi_clr;
  logic        b_flag, hijack, vec_nmi, start;
  logic        seq_done_q, seq_done_nxt;
  logic        push_pch, push_pcl, push_psr, set_i, load_vec_lo, load_vec_hi;
  logic [15:0] vec_base, vec_addr;
  logic        unused_psr_bits;

  assign unused_psr_bits = ^bus.psr_in[5:4];

  always_comb begin
    start_src = SRC_NONE;
    if (bus.brk_req)                         start_src = SRC_BRK;
    else if (nmi_pend)                       start_src = SRC_NMI;
    else if (!bus.irq_n && !bus.psr_in[2])   start_src = SRC_IRQ;
  end

  assign start    = (state == IDLE) && bus.instr_bound && (start_src != SRC_NONE);
  assign nmi_edge = nmi_q && !bus.nmi_n;
  assign vec_nmi  = (src == SRC_NMI) || hijack;
  assign vec_base = vec_nmi ? NMI_VEC : IRQ_VEC;
  assign nmi_clr  = (state == VEC_LO) && bus.bus_ready && vec_nmi;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      seq_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      seq_done_q <= seq_done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    seq_done_nxt = 1'b0;
    push_pch     = 1'b0;
    push_pcl     = 1'b0;
    push_psr     = 1'b0;
    set_i        = 1'b0;
    load_vec_lo  = 1'b0;
    load_vec_hi  = 1'b0;
    vec_addr     = 16'h0000;
    case (state)
      IDLE: if (start) state_nxt = PUSH_PCH;
      PUSH_PCH: begin
        push_pch = 1'b1;
        if (bus.bus_ready) state_nxt = PUSH_PCL;
      end
      PUSH_PCL: begin
        push_pcl = 1'b1;
        if (bus.bus_ready) state_nxt = PUSH_P;
      end
      PUSH_P: begin
        push_psr = 1'b1;
        if (bus.bus_ready) state_nxt = VEC_LO;
      end
      VEC_LO: begin
        load_vec_lo = 1'b1;
        set_i       = 1'b1;
        vec_addr    = vec_base;
        if (bus.bus_ready) state_nxt = VEC_HI;
      end
      VEC_HI: begin
        load_vec_hi = 1'b1;
        vec_addr    = vec_base + 16'd1;
        if (bus.bus_ready) begin
          state_nxt    = IDLE;
          seq_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new edge in the clearing cycle wins, so back-to-back NMIs are never lost.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nmi_q    <= 1'b1;
      nmi_pend <= 1'b0;
      src      <= SRC_NONE;
      b_flag   <= 1'b0;
      hijack   <= 1'b0;
    end else begin
      nmi_q    <= bus.nmi_n;
      nmi_pend <= nmi_edge || (nmi_pend && !nmi_clr);
      if (start) begin
        src    <= start_src;
        b_flag <= (start_src == SRC_BRK);
        hijack <= 1'b0;
      end else if (nmi_pend && (src != SRC_NMI) &&
                   (state == PUSH_PCH || state == PUSH_PCL || state == PUSH_P)) begin
        hijack <= 1'b1;
      end
    end
  end

  assign bus.seq_active  = (state != IDLE);
  assign bus.push_pch    = push_pch;
  assign bus.push_pcl    = push_pcl;
  assign bus.push_psr    = push_psr;
  assign bus.psr_push    = {bus.psr_in[7:6], 1'b1, b_flag, bus.psr_in[3:0]};
  assign bus.set_i       = set_i;
  assign bus.vec_addr    = vec_addr;
  assign bus.load_vec_lo = load_vec_lo;
  assign bus.load_vec_hi = load_vec_hi;
  assign bus.seq_done    = seq_done_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: BRK, IRQ mask/level, NMI hijack,
// bus stalls, reset mid-sequence and NMI arriving late in an IRQ entry.
module tb_interrupt_sequencer;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  interrupt_sequencer_if bus();
  interrupt_sequencer dut (.clk(clk), .nrst(nrst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // {seq_active, push_pch, push_pcl, push_psr, set_i, load_vec_lo, load_vec_hi, seq_done}
  localparam logic [7:0] O_IDLE = 8'h00, O_PCH = 8'hC0, O_PCL = 8'hA0, O_PP = 8'h90;
  localparam logic [7:0] O_VLO = 8'h8C, O_VHI = 8'h82, O_DONE = 8'h01;

  function automatic logic [7:0] outs();
    return {bus.seq_active, bus.push_pch, bus.push_pcl, bus.push_psr,
            bus.set_i, bus.load_vec_lo, bus.load_vec_hi, bus.seq_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.instr_bound = 1'b0; bus.brk_req = 1'b0; bus.irq_n = 1'b1; bus.nmi_n = 1'b1;
    bus.bus_ready = 1'b1;   bus.psr_in = 8'h00;
    #1;
    total++;
    if (outs() !== O_IDLE) begin bad++; $display("FAIL reset_outs got=%h want=%h", outs(), O_IDLE); end
    total++;
    if (bus.psr_push !== 8'h20) begin bad++; $display("FAIL reset_psr_push got=%h want=20", bus.psr_push); end
    total++;
    if (bus.vec_addr !== 16'h0000 || dut.nmi_pend !== 1'b0) begin
      bad++; $display("FAIL reset_vec_pend vec=%h pend=%b want 0000/0", bus.vec_addr, dut.nmi_pend);
    end
    tick(); tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_brk();
    logic [7:0]  eo [7];
    logic [15:0] ev [7];
    eo = '{O_PCH, O_PCL, O_PP, O_VLO, O_VHI, O_DONE, O_IDLE};
    ev = '{16'h0, 16'h0, 16'h0, 16'hFFFE, 16'hFFFF, 16'h0, 16'h0};
    bus.psr_in = 8'hC3; bus.instr_bound = 1'b1; bus.brk_req = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      total++;
      if (outs() !== eo[i] || bus.vec_addr !== ev[i]) begin
        bad++; $display("FAIL brk_step%0d outs=%h vec=%h want outs=%h vec=%h", i, outs(), bus.vec_addr, eo[i], ev[i]);
      end
      if (i == 2) begin
        total++;
        if (bus.psr_push !== 8'hF3) begin bad++; $display("FAIL brk_psr_push got=%h want=F3", bus.psr_push); end
      end
      // boundary held high through VEC_LO must be ignored while active
      if (i == 3) begin bus.instr_bound = 1'b0; bus.brk_req = 1'b0; end
      tick();
    end
  endtask

  task automatic test_irq();
    logic [7:0]  eo [7];
    logic [15:0] ev [7];
    eo = '{O_PCH, O_PCL, O_PP, O_VLO, O_VHI, O_DONE, O_IDLE};
    ev = '{16'h0, 16'h0, 16'h0, 16'hFFFE, 16'hFFFF, 16'h0, 16'h0};
    bus.psr_in = 8'h04; bus.irq_n = 1'b0; bus.instr_bound = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outs() !== O_IDLE) begin bad++; $display("FAIL irq_masked%0d outs=%h want=%h", i, outs(), O_IDLE); end
    end
    bus.psr_in = 8'h00;
    tick();
    for (int i = 0; i < 7; i++) begin
      total++;
      if (outs() !== eo[i] || bus.vec_addr !== ev[i]) begin
        bad++; $display("FAIL irq_step%0d outs=%h vec=%h want outs=%h vec=%h", i, outs(), bus.vec_addr, eo[i], ev[i]);
      end
      if (i == 2) begin
        total++;
        if (bus.psr_push !== 8'h20) begin bad++; $display("FAIL irq_psr_push got=%h want=20", bus.psr_push); end
      end
      if (i == 0) begin bus.instr_bound = 1'b0; bus.irq_n = 1'b1; end
      tick();
    end
    bus.irq_n = 1'b0;
    tick(); tick();
    bus.irq_n = 1'b1; bus.instr_bound = 1'b1;
    tick();
    total++;
    if (outs() !== O_IDLE) begin bad++; $display("FAIL irq_level outs=%h want=%h", outs(), O_IDLE); end
    bus.instr_bound = 1'b0;
    tick();
  endtask

  task automatic test_hijack();
    logic [7:0]  eo [6];
    logic [15:0] ev [6];
    eo = '{O_PCH, O_PCL, O_PP, O_VLO, O_VHI, O_DONE};
    ev = '{16'h0, 16'h0, 16'h0, 16'hFFFA, 16'hFFFB, 16'h0};
    bus.psr_in = 8'h00; bus.irq_n = 1'b0; bus.instr_bound = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (outs() !== eo[i] || bus.vec_addr !== ev[i]) begin
        bad++; $display("FAIL hijack_step%0d outs=%h vec=%h want outs=%h vec=%h", i, outs(), bus.vec_addr, eo[i], ev[i]);
      end
      if (i == 2) begin
        total++;
        if (bus.psr_push !== 8'h20) begin bad++; $display("FAIL hijack_psr_push got=%h want=20", bus.psr_push); end
      end
      if (i == 3) begin
        total++;
        if (dut.nmi_pend !== 1'b1) begin bad++; $display("FAIL hijack_pend_vlo got=%b want=1", dut.nmi_pend); end
      end
      if (i == 4) begin
        total++;
        if (dut.nmi_pend !== 1'b0) begin bad++; $display("FAIL hijack_pend_clr got=%b want=0", dut.nmi_pend); end
      end
      if (i == 0) begin bus.instr_bound = 1'b0; bus.irq_n = 1'b1; end
      if (i == 1) bus.nmi_n = 1'b0;
      tick();
    end
    bus.nmi_n = 1'b1;
    tick();
  endtask

  task automatic test_stall();
    logic [7:0]  eo [10];
    logic [15:0] ev [10];
    eo = '{O_PCH, O_PCL, O_PP, O_PP, O_PP, O_PP, O_VLO, O_VHI, O_DONE, O_IDLE};
    ev = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFE, 16'hFFFF, 16'h0, 16'h0};
    bus.psr_in = 8'h00; bus.instr_bound = 1'b1; bus.brk_req = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (outs() !== eo[i] || bus.vec_addr !== ev[i]) begin
        bad++; $display("FAIL stall_step%0d outs=%h vec=%h want outs=%h vec=%h", i, outs(), bus.vec_addr, eo[i], ev[i]);
      end
      if (i == 3) begin
        total++;
        if (bus.psr_push !== 8'h30) begin bad++; $display("FAIL stall_psr_push got=%h want=30", bus.psr_push); end
      end
      if (i == 0) begin bus.instr_bound = 1'b0; bus.brk_req = 1'b0; end
      bus.bus_ready = !(i >= 2 && i <= 4);
      tick();
    end
    bus.bus_ready = 1'b1;
  endtask

  task automatic test_nmi_vec_hi();
    logic [7:0]  eo [6];
    logic [15:0] ev [6];
    logic [7:0]  no [7];
    logic [15:0] nv [7];
    eo = '{O_PCH, O_PCL, O_PP, O_VLO, O_VHI, O_DONE};
    ev = '{16'h0, 16'h0, 16'h0, 16'hFFFE, 16'hFFFF, 16'h0};
    no = '{O_PCH, O_PCL, O_PP, O_VLO, O_VHI, O_DONE, O_IDLE};
    nv = '{16'h0, 16'h0, 16'h0, 16'hFFFA, 16'hFFFB, 16'h0, 16'h0};
    bus.psr_in = 8'h00; bus.irq_n = 1'b0; bus.instr_bound = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (outs() !== eo[i] || bus.vec_addr !== ev[i]) begin
        bad++; $display("FAIL late_irq_step%0d outs=%h vec=%h want outs=%h vec=%h", i, outs(), bus.vec_addr, eo[i], ev[i]);
      end
      if (i == 0) begin bus.instr_bound = 1'b0; bus.irq_n = 1'b1; end
      if (i == 4) bus.nmi_n = 1'b0;
      if (i == 5) begin
        total++;
        if (dut.nmi_pend !== 1'b1) begin bad++; $display("FAIL late_pend got=%b want=1", dut.nmi_pend); end
        bus.nmi_n = 1'b1; bus.instr_bound = 1'b1;
      end
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (outs() !== no[i] || bus.vec_addr !== nv[i]) begin
        bad++; $display("FAIL late_nmi_step%0d outs=%h vec=%h want outs=%h vec=%h", i, outs(), bus.vec_addr, no[i], nv[i]);
      end
      if (i == 2) begin
        total++;
        if (bus.psr_push !== 8'h20) begin bad++; $display("FAIL late_nmi_psr got=%h want=20", bus.psr_push); end
      end
      if (i == 4) begin
        total++;
        if (dut.nmi_pend !== 1'b0) begin bad++; $display("FAIL late_nmi_pend got=%b want=0", dut.nmi_pend); end
      end
      if (i == 0) bus.instr_bound = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.psr_in = 8'h00; bus.irq_n = 1'b0; bus.instr_bound = 1'b1;
    tick();
    bus.instr_bound = 1'b0; bus.irq_n = 1'b1; bus.nmi_n = 1'b0;
    tick(); tick(); tick();
    total++;
    if (outs() !== O_VLO) begin bad++; $display("FAIL rstmid_pre outs=%h want=%h", outs(), O_VLO); end
    nrst = 1'b0; bus.nmi_n = 1'b1;
    #1;
    total++;
    if (bus.seq_active !== 1'b0 || bus.load_vec_lo !== 1'b0 || outs() !== O_IDLE) begin
      bad++; $display("FAIL rstmid_async outs=%h want=%h", outs(), O_IDLE);
    end
    total++;
    if (dut.nmi_pend !== 1'b0) begin bad++; $display("FAIL rstmid_pend got=%b want=0", dut.nmi_pend); end
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outs() !== O_IDLE) begin bad++; $display("FAIL rstmid_idle%0d outs=%h want=%h", i, outs(), O_IDLE); end
    end
  endtask

  initial begin
    test_reset();
    test_brk();
    test_irq();
    test_hijack();
    test_stall();
    test_nmi_vec_hi();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
